// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned LEN_W_DEF   = 4;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_CR,
    ST_LF
  } state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Producer-side message bus and UART write port of the transmit scheduler.
interface uart_tx_sched_if
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
);

  logic [NREQ-1:0]           req;
  logic [NREQ*LEN_W-1:0]     msg_len;
  logic [NREQ*MAX_LEN*8-1:0] msg_data;
  logic                      tx_full;
  logic                      wr_uart;
  logic [7:0]                wr_data;
  logic [NREQ-1:0]           ack;
  logic [NREQ-1:0]           done;
  logic                      busy;

  // Producers plus the UART FIFO status side
  modport master (
    output req, msg_len, msg_data, tx_full,
    input  wr_uart, wr_data, ack, done, busy
  );

  modport slave (
    input  req, msg_len, msg_data, tx_full,
    output wr_uart, wr_data, ack, done, busy
  );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  input  logic                 i_en,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] w_j;
  logic             w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = IDX_W'((32'(i_ptr) + k) % N);
      if (i_en && !w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_gnt_idx  = w_j;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler streaming whole producer messages into the UART TX FIFO.
// Define UART_TX_SCHED_CRLF_EN to append CR/LF after every message.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_sched_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned BUF_W = MAX_LEN * 8;

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_idx, w_idx_nxt, r_len, w_len_nxt, w_len_sel, w_idx_inc;
  logic [BUF_W-1:0] r_buf, w_buf_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt, r_ptr, w_ptr_nxt, w_gnt_idx;
  logic [NREQ-1:0]  r_ack, w_ack_nxt, r_done, w_done_nxt, w_gnt;
  logic             w_wr, w_fin;
  logic [7:0]       w_data;

  rr_arbiter #(.N(NREQ)) u_arb (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .i_en      (r_state == ST_IDLE),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_len_sel = bus.msg_len[int'(w_gnt_idx)*LEN_W +: LEN_W];
  assign w_idx_inc = r_idx + LEN_W'(1);

  // Next-state, capture and UART write strobe
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_buf_nxt   = r_buf;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_wr        = 1'b0;
    w_fin       = 1'b0;
    w_data      = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (|w_gnt) begin
          w_len_nxt   = (w_len_sel > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : w_len_sel;
          w_buf_nxt   = bus.msg_data[int'(w_gnt_idx)*BUF_W +: BUF_W];
          w_idx_nxt   = '0;
          w_owner_nxt = w_gnt_idx;
          w_ptr_nxt   = (32'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + IDX_W'(1);
          w_ack_nxt   = w_gnt;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // An empty message skips straight to the trailer / completion
        if (r_idx < r_len) begin
          w_data = r_buf[int'(r_idx)*8 +: 8];
          w_wr   = ~bus.tx_full;
          if (w_wr) begin
            w_idx_nxt = w_idx_inc;
            w_fin     = (w_idx_inc == r_len);
          end
        end else begin
          w_fin = 1'b1;
        end
        if (w_fin) begin
`ifdef UART_TX_SCHED_CRLF_EN
          w_state_nxt = ST_CR;
`else
          w_state_nxt         = ST_IDLE;
          w_done_nxt[r_owner] = 1'b1;
`endif
        end
      end
`ifdef UART_TX_SCHED_CRLF_EN
      ST_CR: begin
        w_data = ASCII_CR;
        w_wr   = ~bus.tx_full;
        if (w_wr) w_state_nxt = ST_LF;
      end
      ST_LF: begin
        w_data = ASCII_LF;
        w_wr   = ~bus.tx_full;
        if (w_wr) begin
          w_state_nxt         = ST_IDLE;
          w_done_nxt[r_owner] = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_buf   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_ack   <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_buf   <= w_buf_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ack   <= w_ack_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.wr_uart = w_wr;
  assign bus.wr_data = w_data;
  assign bus.ack     = r_ack;
  assign bus.done    = r_done;
  assign bus.busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (default and CRLF builds).
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
`ifdef UART_TX_SCHED_CRLF_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  uart_tx_sched #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int              n_checks = 0;
  int              n_errors = 0;
  logic [7:0]      cap_bytes [32];
  int              cap_n, ack_cyc, done_cyc;
  logic [NREQ-1:0] ack_val, done_val;
  int              stall_lo, stall_hi;
  logic [63:0]     msg_a, msg_b;
  logic [3:0]      exp_oh;
  logic [7:0]      exp_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req     = '0;
    bus.tx_full = 1'b0;
    reset_n     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_msg(input int p, input int len, input logic [63:0] b);
    bus.msg_len[p*LEN_W +: LEN_W] = LEN_W'(len);
    for (int k = 0; k < int'(MAX_LEN); k++)
      bus.msg_data[(p*int'(MAX_LEN)+k)*8 +: 8] = b[k*8 +: 8];
  endtask

  // Cycle 0 is the cycle in which the caller raised req; records writes, ack and done.
  task automatic capture(input int max_cyc);
    cap_n    = 0;
    ack_cyc  = -1;
    done_cyc = -1;
    ack_val  = '0;
    done_val = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk);
      #1;
      bus.tx_full = (c >= stall_lo && c <= stall_hi);
      #1;
      if (bus.wr_uart) begin
        if (cap_n < 32) cap_bytes[cap_n] = bus.wr_data;
        cap_n++;
      end
      if (bus.ack != '0 && ack_cyc < 0) begin
        ack_cyc = c;
        ack_val = bus.ack;
        bus.req = bus.req & ~bus.ack;
      end
      if (bus.done != '0) begin
        done_cyc = c;
        done_val = bus.done;
        break;
      end
    end
    bus.tx_full = 1'b0;
  endtask

  task automatic check_payload(input string tag, input logic [63:0] b, input int len);
    for (int k = 0; k < len; k++)
      check($sformatf("%s_byte%0d", tag, k), 64'(cap_bytes[k]), 64'(b[k*8 +: 8]));
  endtask

  task automatic check_crlf(input string tag, input int pos);
`ifdef UART_TX_SCHED_CRLF_EN
    check($sformatf("%s_cr", tag), 64'(cap_bytes[pos]),   64'h0D);
    check($sformatf("%s_lf", tag), 64'(cap_bytes[pos+1]), 64'h0A);
`else
    if (pos < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req      = '0;
    bus.msg_len  = '0;
    bus.msg_data = '0;
    bus.tx_full  = 1'b0;
    stall_lo     = 99;
    stall_hi     = 0;
    reset_n      = 1'b0;
    tick();
    check("rst_busy",    64'(bus.busy),    64'h0);
    check("rst_wr_uart", 64'(bus.wr_uart), 64'h0);
    check("rst_wr_data", 64'(bus.wr_data), 64'h0);
    check("rst_ack",     64'(bus.ack),     64'h0);
    check("rst_done",    64'(bus.done),    64'h0);

    // Requester 1 sends "3:45:7"
    do_reset();
    msg_a = 64'h0000_373A_3534_3A33;
    set_msg(1, 6, msg_a);
    bus.req = 4'b0010;
    capture(30);
    check("t1_ack_cyc",  64'(ack_cyc),  64'(1));
    check("t1_ack",      64'(ack_val),  64'h2);
    check("t1_nwr",      64'(cap_n),    64'(6 + EXTRA));
    check_payload("t1", msg_a, 6);
    check_crlf("t1", 6);
    check("t1_done_cyc", 64'(done_cyc), 64'(7 + EXTRA));
    check("t1_done",     64'(done_val), 64'h2);
    check("t1_idle",     64'(bus.busy), 64'h0);

    // All four requesting continuously, one byte each: order 0,1,2,3,0
    do_reset();
    for (int p = 0; p < 4; p++) set_msg(p, 1, 64'(8'h41 + p));
    bus.req = 4'b1111;
    for (int m = 0; m < 5; m++) begin
      exp_oh = 4'(1 << (m % 4));
      exp_b  = 8'(8'h41 + (m % 4));
      tick();
      check($sformatf("t2_ack%0d", m),  64'(bus.ack),     64'(exp_oh));
      check($sformatf("t2_data%0d", m), 64'(bus.wr_data), 64'(exp_b));
      check($sformatf("t2_wr%0d", m),   64'(bus.wr_uart), 64'h1);
      for (int w = 0; w < 6 && bus.done == '0; w++) tick();
      check($sformatf("t2_done%0d", m), 64'(bus.done), 64'(exp_oh));
      check($sformatf("t2_gap%0d", m),  64'(bus.busy), 64'h0);
      if (m == 4) bus.req = '0;
    end
    tick();

    // Three-cycle tx_full stall after the third byte of a 5-byte message
    msg_b = 64'h0000_0055_4433_2211;
    set_msg(0, 5, msg_b);
    stall_lo = 4;
    stall_hi = 6;
    bus.req  = 4'b0001;
    capture(30);
    stall_lo = 99;
    stall_hi = 0;
    check("t3_ack",      64'(ack_val),  64'h1);
    check("t3_nwr",      64'(cap_n),    64'(5 + EXTRA));
    check_payload("t3", msg_b, 5);
    check_crlf("t3", 5);
    check("t3_done_cyc", 64'(done_cyc), 64'(9 + EXTRA));
    tick();

    // Zero-length message from requester 2
    set_msg(2, 0, 64'h0);
    bus.req = 4'b0100;
    capture(30);
    check("t4_ack_cyc",  64'(ack_cyc),  64'(1));
    check("t4_ack",      64'(ack_val),  64'h4);
    check("t4_nwr",      64'(cap_n),    64'(EXTRA));
    check_crlf("t4", 0);
    check("t4_done_cyc", 64'(done_cyc), 64'(2 + EXTRA));
    check("t4_done",     64'(done_val), 64'h4);
    tick();

    // Length 12 clamped to MAX_LEN 8
    msg_a = 64'h8877_6655_4433_2211;
    set_msg(3, 12, msg_a);
    bus.req = 4'b1000;
    capture(40);
    check("t5_nwr",      64'(cap_n),    64'(8 + EXTRA));
    check_payload("t5", msg_a, 8);
    check_crlf("t5", 8);
    check("t5_done_cyc", 64'(done_cyc), 64'(9 + EXTRA));
    tick();

    // Reset in the middle of a 6-byte message
    do_reset();
    msg_a = 64'h0000_373A_3534_3A33;
    set_msg(1, 6, msg_a);
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick();
    tick();
    check("t6_byte2", 64'(bus.wr_data), 64'h34);
    tick();
    check("t6_pre_wr", 64'(bus.wr_uart), 64'h1);
    reset_n = 1'b0;
    #1;
    check("t6_busy",    64'(bus.busy),    64'h0);
    check("t6_wr_uart", 64'(bus.wr_uart), 64'h0);
    check("t6_wr_data", 64'(bus.wr_data), 64'h0);
    check("t6_ack",     64'(bus.ack),     64'h0);
    check("t6_done",    64'(bus.done),    64'h0);
    set_msg(0, 2, 64'h0000_0000_0000_B2B1);
    set_msg(3, 1, 64'h0000_0000_0000_00C3);
    bus.req = 4'b1001;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    capture(30);
    check("t6_first",  64'(ack_val),  64'h1);
    check("t6_first_done", 64'(done_val), 64'h1);
    capture(30);
    check("t6_second", 64'(ack_val),  64'h8);
    check("t6_second_byte", 64'(cap_bytes[0]), 64'hC3);

    // After reset with only req[3] pending, requester 3 wins directly
    reset_n = 1'b0;
    bus.req = 4'b1000;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    capture(30);
    check("t6_only3",     64'(ack_val), 64'h8);
    check("t6_only3_cyc", 64'(ack_cyc), 64'(1));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
